// File: rtl/serial_add_sequencer_if.sv
// Handshake and serial-adder signal bundle for serial_add_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface serial_add_sequencer_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_a;
    logic         ser_b;
    logic         ser_clr;
    logic         ser_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    modport slave (
        input  in_valid, in_a, in_b, ser_sum, out_ready,
        output in_ready, ser_a, ser_b, ser_clr, out_valid, out_sum, out_carry
    );

    modport master (
        output in_valid, in_a, in_b, ser_sum, out_ready,
        input  in_ready, ser_a, ser_b, ser_clr, out_valid, out_sum, out_carry
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Feeds W-bit operand pairs LSB-first into an external 1-bit serial adder and
// reassembles the W+1-bit result, with valid/ready handshakes on both sides.
module serial_add_sequencer #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_sequencer_if.slave bus
);
    localparam int CW = (W < 2) ? 1 : $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [W-1:0]  sa_reg, sa_next;
    logic [W-1:0]  sb_reg, sb_next;
    logic [W:0]    res_reg, res_next;
    logic [W-1:0]  sum_reg, sum_next;
    logic          carry_reg, carry_next;
    logic [W:0]    res_shift;

    // Each SHIFT cycle the adder's sum bit enters at the top; after W+1 cycles
    // bit 0 holds the first (LSB) sum bit and bit W holds the flushed carry.
    assign res_shift = {bus.ser_sum, res_reg[W:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sa_reg    <= '0;
            sb_reg    <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            res_reg   <= res_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        res_next   = res_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_next    = bus.in_a;
                    sb_next    = bus.in_b;
                    res_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                res_next = res_shift;
                sa_next  = sa_reg >> 1;
                sb_next  = sb_reg >> 1;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    sum_next   = res_shift[W-1:0];
                    carry_next = res_shift[W];
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The final SHIFT cycle drives zeros so the adder emits its carry as the sum bit.
    assign bus.ser_a     = (state_reg == SHIFT) && (cnt_reg != LAST) && sa_reg[0];
    assign bus.ser_b     = (state_reg == SHIFT) && (cnt_reg != LAST) && sb_reg[0];
    assign bus.ser_clr   = (state_reg != SHIFT);
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_sum   = sum_reg;
    assign bus.out_carry = carry_reg;
endmodule
